// File: rtl/bel_fft_project_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bel_fft_project_pkg
// Purpose  : Shared constants, twiddle word layout and FSM encoding for the
//            FFT twiddle fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package bel_fft_project_pkg;

   localparam int ROM_AW    = 8;
   localparam int DATA_W    = 64;
   localparam int TW_HALF_W = DATA_W / 2;

   // {re, im} Q1.31 word layout
   localparam int TW_RE_MSB = DATA_W - 1;
   localparam int TW_RE_LSB = TW_HALF_W;
   localparam int TW_IM_MSB = TW_HALF_W - 1;
   localparam int TW_IM_LSB = 0;

   localparam int STAGE_W   = 4;
   localparam int TAG_W     = STAGE_W + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } tw_state_t;

endpackage
`default_nettype wire

// File: rtl/bel_fft_project_twiddle_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bel_fft_project_twiddle_fifo
// Purpose  : Small synchronous FIFO with occupancy count, holding twiddle
//            words together with their stage/last/final tag.
// Revision : 1.0 - initial release
// ============================================================================
module bel_fft_project_twiddle_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 70
)(
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   // A push into a full FIFO is accepted only when the head leaves in the same cycle
   assign w_pop   = i_pop && (r_count != '0);
   assign w_push  = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

   assign o_valid = (r_count != '0);
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/bel_fft_project_twiddle_fetch.sv
`default_nettype none
// ============================================================================
// Module   : bel_fft_project_twiddle_fetch
// Purpose  : Generates the radix-2 DIT twiddle address sequence, reads the
//            twiddle ROM and streams (optionally conjugated) twiddles out.
// Revision : 1.0 - initial release
// ============================================================================
module bel_fft_project_twiddle_fetch
   import bel_fft_project_pkg::*;
#(
   parameter int ROM_AW     = bel_fft_project_pkg::ROM_AW,
   parameter int DATA_W     = bel_fft_project_pkg::DATA_W,
   parameter int FIFO_DEPTH = 4
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        log2n,
   input  logic              inverse,
   output logic              busy,
   output logic              done,
   output logic              rom_clken,
   output logic [ROM_AW-1:0] rom_address,
   input  logic [DATA_W-1:0] rom_q,
   output logic              tw_valid,
   input  logic              tw_ready,
   output logic [DATA_W-1:0] tw_data,
   output logic [3:0]        tw_stage,
   output logic              tw_last,
   output logic              tw_final
);

   localparam int HALF_W = DATA_W / 2;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int FW     = DATA_W + 6;

   tw_state_t         r_state;
   logic [3:0]        r_log2n;
   logic              r_inverse;
   logic [3:0]        r_stage;
   logic [ROM_AW-1:0] r_bfly;
   logic              r_inflight;
   logic [3:0]        r_cap_stage;
   logic              r_cap_last;
   logic              r_cap_final;
   logic              r_busy;
   logic              r_done;

   logic              w_start_ok;
   logic              w_issue;
   logic              w_bfly_last;
   logic              w_stage_last;
   logic [ROM_AW:0]   w_half;
   logic [ROM_AW-1:0] w_jmask;
   logic [3:0]        w_shamt;
   logic [CNT_W-1:0]  w_occ;
   logic [CNT_W:0]    w_pend;
   logic              w_pop;
   logic              w_fifo_valid;
   logic [FW-1:0]     w_fifo_out;
   logic [FW-1:0]     w_push_word;
   logic [HALF_W-1:0] w_im;
   logic [HALF_W-1:0] w_im_conj;

   assign w_start_ok   = (r_state == IDLE) && start && (log2n != 4'd0) && (int'(log2n) <= ROM_AW);

   // Stage s uses twiddle index j = b mod 2^s, scaled onto the full-circle ROM
   assign w_half       = (ROM_AW+1)'(1) << (r_log2n - 4'd1);
   assign w_bfly_last  = ({1'b0, r_bfly} == (w_half - (ROM_AW+1)'(1)));
   assign w_stage_last = (r_stage == (r_log2n - 4'd1));
   assign w_jmask      = (ROM_AW'(1) << r_stage) - ROM_AW'(1);
   assign w_shamt      = 4'(ROM_AW - 1) - r_stage;

   assign w_pend       = {1'b0, w_occ} + {{CNT_W{1'b0}}, r_inflight};
   assign w_issue      = (r_state == RUN) && (w_pend < (CNT_W+1)'(FIFO_DEPTH));
   assign rom_clken    = w_issue;
   assign rom_address  = (r_bfly & w_jmask) << w_shamt;

   // Conjugation saturates the single unrepresentable negation
   assign w_im         = rom_q[HALF_W-1:0];
   assign w_im_conj    = (w_im == {1'b1, {(HALF_W-1){1'b0}}}) ? {1'b0, {(HALF_W-1){1'b1}}}
                                                              : (~w_im + HALF_W'(1));
   assign w_push_word  = {rom_q[DATA_W-1:HALF_W], (r_inverse ? w_im_conj : w_im),
                          r_cap_stage, r_cap_last, r_cap_final};

   assign w_pop        = w_fifo_valid && tw_ready;

   bel_fft_project_twiddle_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_push  (r_inflight),
      .i_data  (w_push_word),
      .i_pop   (w_pop),
      .o_data  (w_fifo_out),
      .o_valid (w_fifo_valid),
      .o_count (w_occ)
   );

   assign tw_valid = w_fifo_valid;
   assign tw_data  = w_fifo_out[FW-1:6];
   assign tw_stage = w_fifo_out[5:2];
   assign tw_last  = w_fifo_out[1];
   assign tw_final = w_fifo_out[0];
   assign busy     = r_busy;
   assign done     = r_done;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_log2n     <= 4'd0;
         r_inverse   <= 1'b0;
         r_stage     <= 4'd0;
         r_bfly      <= '0;
         r_inflight  <= 1'b0;
         r_cap_stage <= 4'd0;
         r_cap_last  <= 1'b0;
         r_cap_final <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_inflight <= w_issue;
         if (w_issue) begin
            r_cap_stage <= r_stage;
            r_cap_last  <= w_bfly_last;
            r_cap_final <= w_bfly_last && w_stage_last;
         end
         case (r_state)
            IDLE: begin
               if (w_start_ok) begin
                  r_state   <= RUN;
                  r_log2n   <= log2n;
                  r_inverse <= inverse;
                  r_stage   <= 4'd0;
                  r_bfly    <= '0;
                  r_busy    <= 1'b1;
               end
            end
            RUN: begin
               if (w_issue) begin
                  if (w_bfly_last) begin
                     r_bfly <= '0;
                     if (w_stage_last) begin
                        r_state <= DRAIN;
                     end else begin
                        r_stage <= r_stage + 4'd1;
                     end
                  end else begin
                     r_bfly <= r_bfly + ROM_AW'(1);
                  end
               end
            end
            DRAIN: begin
               if (w_pop && tw_final) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
